inv_ark_stage: RTL and testbench
================================

# inv_ark_stage

Registered inverse AddRoundKey stage of the iterative AES-128 decryption datapath. It sits directly downstream of the inverse SubBytes stage. It XORs each 128-bit state beat with the round key selected by an internal descending round counter, and hands the result to inverse MixColumns, or to the plaintext output on round 0. It holds the 11 expanded round keys in a local key store and uses a 2-entry skid buffer, so the upstream ready is registered and full throughput is kept.

## Interface
- NR, default 10: number of rounds handled per block; the key store holds NR+1 keys, indices 0..NR.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- key_wr_en  input  1  round-key write strobe.
- key_wr_idx  input  4  round-key index, 0..NR.
- key_wr_data  input  [0:127]  round key; bit 0 is the MSB of byte 0.
- key_wr_err  output  1  one-cycle pulse: write rejected (busy, or index > NR).
- in_valid  input  1  in_state is valid.
- in_ready  output  1  stage can accept a beat; registered.
- in_state  input  [0:127]  state from inverse SubBytes, same byte ordering.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  downstream accepts.
- out_state  output  [0:127]  in_state XOR round key.
- out_round  output  4  round index used for this beat.
- out_last  output  1  out_round == 0, i.e. this beat is final plaintext.

## Operation
- Beat handshake: a beat is accepted on a cycle with in_valid && in_ready. A beat is delivered on a cycle with out_valid && out_ready.
- Round counter rnd (4 bits):
  - Resets to NR-1.
  - Each accepted beat uses key[rnd]; rnd then decrements.
  - Wrap-around: after the beat with rnd == 0, rnd reloads to NR-1. One block is therefore exactly NR consecutive accepted beats (rounds NR-1..0).
  - The initial key[NR] AddRoundKey is outside this stage. key[NR] is stored only for use by that external stage's read path, not by this stage.
- Datapath: on accept, compute in_state ^ key[rnd] and tag it with round = rnd and last = (rnd == 0). This is pure XOR, with no carry or width change.
- Buffer: a main output register plus one skid register.
  - Accept while main is empty, or main is draining this cycle: the beat goes to main.
  - Accept while main is full and stalled: the beat goes to skid.
  - When main drains and skid is full, skid moves to main on the same edge.
  - in_ready (next) = skid empty after this edge.
  - Beat order is preserved.
- Key store: NR+1 registers of 128 bits, all cleared to 0 by rst.
  - Idle means rnd == NR-1, main is empty, and skid is empty.
  - A write succeeds only when idle and key_wr_idx <= NR.
  - Otherwise the store is unchanged and key_wr_err pulses on the next cycle.
  - A successful write is visible to a beat accepted on the following cycle or later.
- Simultaneous key write and beat accept in an idle cycle: the write succeeds, and the beat uses the old key value.
- Reset mid-block: all buffered beats are discarded, rnd returns to NR-1, and keys are cleared. Upstream must restart the block.

## Timing
Reset values, visible in the cycle after rst is sampled high:

- out_valid = 0
- in_ready = 1
- key_wr_err = 0
- out_state, out_round, out_last = 0

Latency and throughput:

- Latency is 1 cycle: a beat accepted at edge N shows out_valid at N+1 when main was empty or draining.
- Throughput is 1 beat/cycle while out_ready is held high.
- When out_ready is low for 2 or more cycles: main and skid fill, and in_ready drops in the cycle after the skid write.
- Nothing further is accepted until a drain occurs. in_ready rises in the cycle after the first drain.

Output behaviour:

- out_* hold stable while out_valid && !out_ready.
- No combinational path exists from out_ready to in_ready.

## Test plan
- Reset, then load keys k[i] = {16{8'(i)}} for i = 0..10, then stream 10 beats of all-zero state with out_ready = 1. Required: out_round reads 9,8,…,0; out_state = {16{8'(round)}}; out_last is high only on the 10th beat; there is one beat per cycle after 1-cycle latency.
- Same stream with out_ready low for cycles 2–5. Required: in_ready falls after two beats are buffered; no beat is lost or duplicated; order is preserved.
- key_wr_en with idx = 3 issued mid-block (rnd = 6). Required: key_wr_err pulses, and key[3] is unchanged when the round-3 beat passes.
- key_wr_en with idx = 11 while idle. Required: key_wr_err pulses, and no key is modified.
- Two back-to-back blocks of 10 beats. Required: rnd wraps from 0 to 9 with no gap cycle, and the second block's out_round restarts at 9.
- Assert rst on cycle 4 of a block with beats buffered. Required: out_valid = 0 and in_ready = 1 on the next cycle; the next accepted beat has out_round = 9 and out_state = in_state, since keys are cleared to 0.

Source files
------------

// File: rtl/inv_ark_stage.sv
// Registered inverse AddRoundKey stage of the iterative AES-128 decryption datapath.
// XORs each state beat with key[rnd] from a local key store; 2-entry skid buffer keeps in_ready registered.
module inv_ark_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_wr_en,
    input  logic [3:0]   key_wr_idx,
    input  logic [0:127] key_wr_data,
    output logic         key_wr_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic [3:0]   out_round,
    output logic         out_last
);

    localparam logic [3:0] RND_TOP = 4'(NR - 1);
    localparam logic [3:0] NR_IDX  = 4'(NR);

    // Key store must clear on reset, so it is kept in registers rather than RAM.
    logic [0:127] key_reg [0:NR];
    logic [NR:0]  key_sel;

    logic [3:0]   rnd_reg, rnd_next;
    logic         in_ready_reg, in_ready_next;
    logic         key_wr_err_reg;

    logic         main_valid_reg, main_valid_next;
    logic [0:127] main_state_reg, main_state_next;
    logic [3:0]   main_round_reg, main_round_next;
    logic         main_last_reg, main_last_next;

    logic         skid_valid_reg, skid_valid_next;
    logic [0:127] skid_state_reg, skid_state_next;
    logic [3:0]   skid_round_reg, skid_round_next;
    logic         skid_last_reg, skid_last_next;

    logic         accept;
    logic         main_free;
    logic         idle;
    logic         wr_ok;
    logic [0:127] beat_state;
    logic         beat_last;

    assign accept     = in_valid && in_ready_reg;
    assign main_free  = !main_valid_reg || out_ready;
    assign idle       = (rnd_reg == RND_TOP) && !main_valid_reg && !skid_valid_reg;
    assign wr_ok      = key_wr_en && idle && (key_wr_idx <= NR_IDX);
    // Reads the pre-edge key, so a same-cycle write is seen only by later beats.
    assign beat_state = in_state ^ key_reg[rnd_reg];
    assign beat_last  = (rnd_reg == 4'd0);

    generate
        for (genvar gi = 0; gi <= NR; gi++) begin : g_key_sel
            assign key_sel[gi] = wr_ok && (key_wr_idx == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                key_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= NR; i++) begin
                if (key_sel[i]) begin
                    key_reg[i] <= key_wr_data;
                end
            end
        end
    end

    always_comb begin
        rnd_next        = rnd_reg;
        main_valid_next = main_valid_reg;
        main_state_next = main_state_reg;
        main_round_next = main_round_reg;
        main_last_next  = main_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_state_next = skid_state_reg;
        skid_round_next = skid_round_reg;
        skid_last_next  = skid_last_reg;

        if (accept) begin
            rnd_next = (rnd_reg == 4'd0) ? RND_TOP : rnd_reg - 4'd1;
        end

        if (main_free) begin
            // Skid holds the older beat, so it always has priority into main.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_state_next = skid_state_reg;
                main_round_next = skid_round_reg;
                main_last_next  = skid_last_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_valid_next = 1'b1;
                main_state_next = beat_state;
                main_round_next = rnd_reg;
                main_last_next  = beat_last;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_state_next = beat_state;
            skid_round_next = rnd_reg;
            skid_last_next  = beat_last;
        end

        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_reg        <= RND_TOP;
            in_ready_reg   <= 1'b1;
            key_wr_err_reg <= 1'b0;
            main_valid_reg <= 1'b0;
            main_state_reg <= '0;
            main_round_reg <= '0;
            main_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_state_reg <= '0;
            skid_round_reg <= '0;
            skid_last_reg  <= 1'b0;
        end else begin
            rnd_reg        <= rnd_next;
            in_ready_reg   <= in_ready_next;
            key_wr_err_reg <= key_wr_en && !wr_ok;
            main_valid_reg <= main_valid_next;
            main_state_reg <= main_state_next;
            main_round_reg <= main_round_next;
            main_last_reg  <= main_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_state_reg <= skid_state_next;
            skid_round_reg <= skid_round_next;
            skid_last_reg  <= skid_last_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign key_wr_err = key_wr_err_reg;
    assign out_valid  = main_valid_reg;
    assign out_state  = main_state_reg;
    assign out_round  = main_round_reg;
    assign out_last   = main_last_reg;

endmodule

// File: tb/tb_inv_ark_stage.sv
// Directed bench for inv_ark_stage: key load, streaming, stalls, rejected key writes, wrap and reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_inv_ark_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [0:127] key_wr_data;
    logic         key_wr_err;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rnd = 9;
    bit keys_on = 1'b0;
    int first_low;
    int first_high;
    int cyc;

    always #5 clk = ~clk;

    inv_ark_stage #(.NR(10)) dut (
        .clk(clk), .rst(rst),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_wr_err(key_wr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream nbeats of state st; out_ready is low for cycles stall_lo..stall_hi.
    // A busy key write (idx 3) is issued at cycle wr_at when wr_at >= 0.
    task automatic stream(input int nbeats, input logic [127:0] st, input int stall_lo,
                          input int stall_hi, input int wr_at, output int cycles);
        int sent = 0;
        int recv = 0;
        int c = 0;
        bit holding = 1'b0;
        logic [127:0] held = '0;
        logic [127:0] exp_state;
        first_low  = -1;
        first_high = -1;
        while (recv < nbeats && c < 200) begin
            in_valid    = (sent < nbeats);
            in_state    = st;
            out_ready   = !(c >= stall_lo && c <= stall_hi);
            key_wr_en   = (c == wr_at);
            key_wr_idx  = 4'd3;
            key_wr_data = '1;
            if (!in_ready && first_low < 0) first_low = c;
            if (in_ready && first_low >= 0 && first_high < 0) first_high = c;
            if (wr_at >= 0 && c == wr_at + 1) check_val("wr_err_busy", key_wr_err, 1);
            if (out_valid) begin
                if (holding) check_val("hold_state", out_state, held);
                if (out_ready) begin
                    exp_state = st ^ (keys_on ? {16{8'(exp_rnd)}} : 128'h0);
                    $display("[TB] beat %0d round=%0d last=%0d state=%h", recv, out_round, out_last, out_state);
                    check_val("out_round", out_round, 128'(exp_rnd));
                    check_val("out_state", out_state, exp_state);
                    check_val("out_last", out_last, (exp_rnd == 0) ? 1 : 0);
                    exp_rnd = (exp_rnd == 0) ? 9 : exp_rnd - 1;
                    recv++;
                    holding = 1'b0;
                end else begin
                    held    = out_state;
                    holding = 1'b1;
                end
            end
            if (in_valid && in_ready) sent++;
            tick();
            c++;
        end
        if (recv < nbeats) check_val("stream_timeout", 128'(recv), 128'(nbeats));
        in_valid  = 1'b0;
        key_wr_en = 1'b0;
        out_ready = 1'b1;
        cycles    = c;
    endtask

    initial begin
        rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
        in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_key_wr_err", key_wr_err, 0);
        check_val("rst_out_state", out_state, 0);
        check_val("rst_out_round", out_round, 0);
        check_val("rst_out_last", out_last, 0);

        for (int i = 0; i <= 10; i++) begin
            key_wr_en   = 1'b1;
            key_wr_idx  = 4'(i);
            key_wr_data = {16{8'(i)}};
            tick();
            check_val("key_load_err", key_wr_err, 0);
        end
        key_wr_en = 1'b0;
        keys_on   = 1'b1;

        // Single block at full rate: 10 beats delivered by cycle 10.
        stream(10, '0, -1, -1, -1, cyc);
        check_val("full_rate_cycles", 128'(cyc), 128'd11);

        // Rejected write: index out of range while idle.
        key_wr_en = 1'b1; key_wr_idx = 4'd11; key_wr_data = '1;
        tick();
        key_wr_en = 1'b0;
        check_val("wr_err_idx11", key_wr_err, 1);
        tick();
        check_val("wr_err_pulse_end", key_wr_err, 0);

        // Stall on cycles 2-5: skid fills at edge 2, ready drops at 3, returns at 7.
        stream(10, '0, 2, 5, -1, cyc);
        check_val("stall_ready_low", 128'(first_low), 128'd3);
        check_val("stall_ready_high", 128'(first_high), 128'd7);
        check_val("stall_cycles", 128'(cyc), 128'd15);

        // Busy write at rnd 6 must be rejected; round-3 beat still sees key 3.
        stream(10, 128'h0123456789abcdef_fedcba9876543210, -1, -1, 3, cyc);

        // Two back-to-back blocks with no gap cycle.
        stream(20, '0, -1, -1, -1, cyc);
        check_val("b2b_cycles", 128'(cyc), 128'd21);

        // Reset mid-block with beats buffered.
        in_valid = 1'b1; in_state = '1; out_ready = 1'b0;
        tick(); tick(); tick();
        check_val("pre_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        check_val("mid_rst_out_valid", out_valid, 0);
        check_val("mid_rst_in_ready", in_ready, 1);
        exp_rnd = 9;
        keys_on = 1'b0;
        stream(1, 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, -1, -1, -1, cyc);
        check_val("post_rst_cycles", 128'(cyc), 128'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
